mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Shared, sequenced 4x4 unsigned multiply unit for the ALU datapath, arbitrated between two requesters.
- The multiplier operand is processed as two radix-4 digits, one per cycle: each digit times B, shift-accumulated.
- The full 8-bit product, the circular 4-bit result and the Z/N/C/V flags are returned through a valid/ready result port tagged with the requester ID.
- Sits between the instruction/control logic (two issue sources) and the ALU flag/result mux.

Parameters:
- EARLY_EXIT, default 1: when 1, skip the second digit step if a[3:2]==0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle (when valid).
- req0_a  in  4  requester 0 multiplier (digit source).
- req0_b  in  4  requester 0 multiplicand.
- req1_valid  in  1  requester 1 has an operation.
- req1_ready  out  1  requester 1 accept.
- req1_a  in  4  requester 1 multiplier.
- req1_b  in  4  requester 1 multiplicand.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_id  out  1  requester that issued this result.
- res_p  out  8  full product a*b.
- res_y  out  4  circular result, res_p[3:0].
- res_z  out  1  zero flag.
- res_n  out  1  negative flag.
- res_c  out  1  carry/truncation flag.
- res_v  out  1  overflow flag.
- busy  out  1  high in any state except IDLE.

Behaviour:
- States: IDLE, STEP0, STEP1, DONE. Reset to IDLE.
- Reset values:
  - res_valid=0, res_id=0, res_p=0, res_y=0, all flags 0, busy=0.
  - Internal: acc=0, last_grant=1 (so requester 0 wins first).
- IDLE, arbitration:
  - reqN_ready is combinational: high only in IDLE and only for the granted requester. Both readys are low in every other state.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted (round robin).
- Accept cycle T (valid & ready):
  - Latch a, b and id.
  - Update last_grant to id.
  - Clear acc.
  - Go to STEP0.
- STEP0 (T+1):
  - acc <= a[1:0]*b (0..45, via b, b<<1 and b+(b<<1)).
  - If EARLY_EXIT=1 and a[3:2]==0, go to DONE; otherwise go to STEP1.
- STEP1 (T+2):
  - acc <= acc + ((a[3:2]*b)<<2). The 8-bit sum never overflows (max 225).
  - Go to DONE.
- Latency:
  - res_valid rises at T+2 on the early-exit path.
  - res_valid rises at T+3 otherwise, and always when EARLY_EXIT=0.
- DONE:
  - res_valid=1. All res_* outputs are registered and held stable while res_ready=0.
  - On res_valid & res_ready, go to IDLE next cycle and drop res_valid.
  - No request is accepted in the DONE cycle. The earliest next accept is the following cycle.
- Flags, computed from the latched operands and the final acc:
  - Y = P[3:0].
  - Z = (Y==0).
  - N = Y[3].
  - C = |P[7:4] (product did not fit in 4 bits).
  - V = (a!=0) & (b[3] != Y[3]).
- Operand change: input changes after acceptance have no effect on the operation in flight.
- Requester holding: a requester holding valid while not granted keeps its request; no request is dropped.
- Reset in any state:
  - The next cycle is IDLE, with all outputs at reset values and last_grant=1.
  - Any in-flight result is discarded and no res_valid is produced for it.
- Throughput: one result per 3 cycles (early exit) or 4 cycles, with res_ready held high.

Test Plan:
- Reset, then req0 a=3 b=5, EARLY_EXIT=1:
  - Accept at T; res_valid at T+2.
  - res_p=0x0F, res_y=0xF, Z=0, N=1, C=0, V=1, res_id=0.
- req1 a=15 b=15:
  - res_valid at T+3.
  - res_p=0xE1, res_y=0x1, Z=0, N=0, C=1, V=1, res_id=1.
- req0 a=0 b=9 -> res_p=0x00, Z=1, N=0, C=0, V=0. Then a=4 b=4 -> res_p=0x10, res_y=0, Z=1, C=1, V=0.
- Both reqs valid continuously from reset, res_ready=1:
  - Accepted ids alternate 0,1,0,1.
  - Readys are never high together; never high outside IDLE.
- Result back-pressure: res_ready=0 for 5 cycles in DONE:
  - All res_* stay constant; both readys stay low; busy=1.
  - Raising res_ready returns the block to IDLE one cycle later.
- Reset asserted while in STEP1 (a=8 b=3):
  - Next cycle: state IDLE, res_valid=0, busy=0.
  - A simultaneous valid from both requesters then grants req0.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shared two-requester 4x4 unsigned multiplier that handles the
// multiplier operand as two radix-4 digits, one per cycle, and returns the
// product, the circular 4-bit result and Z/N/C/V on a tagged valid/ready port.
module mul_seq_ctrl #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_id,
    output logic [7:0] res_p,
    output logic [3:0] res_y,
    output logic       res_z,
    output logic       res_n,
    output logic       res_c,
    output logic       res_v,
    output logic       busy
);

    localparam int unsigned OP_W = 4;
    localparam int unsigned PP_W = 6;
    localparam int unsigned P_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP0 = 2'd1,
        S_STEP1 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    logic              r_id;
    logic              r_last_grant;
    logic [P_W-1:0]    r_acc;

    logic              r_res_valid;
    logic              r_res_id;
    logic [P_W-1:0]    r_res_p;
    logic              r_res_z;
    logic              r_res_n;
    logic              r_res_c;
    logic              r_res_v;

    logic              w_grant0;
    logic              w_grant1;
    logic [PP_W-1:0]   w_pp0;
    logic [PP_W-1:0]   w_pp1;
    logic [P_W-1:0]    w_sum1;
    logic              w_early;
    logic [P_W-1:0]    w_fin_p;
    logic [OP_W-1:0]   w_fin_y;

    // One radix-4 digit times the multiplicand, built from b, b<<1 and b+(b<<1)
    function automatic logic [PP_W-1:0] digit_mul(input logic [1:0] d, input logic [OP_W-1:0] b);
        logic [PP_W-1:0] b1;
        logic [PP_W-1:0] b2;
        b1 = {2'b00, b};
        b2 = {1'b0, b, 1'b0};
        case (d)
            2'd0:    digit_mul = '0;
            2'd1:    digit_mul = b1;
            2'd2:    digit_mul = b2;
            default: digit_mul = b1 + b2;
        endcase
    endfunction

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last
    assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);

    assign req0_ready = (r_state == S_IDLE) & w_grant0;
    assign req1_ready = (r_state == S_IDLE) & w_grant1;

    // Digit datapath and the value that lands in the result registers
    assign w_pp0   = digit_mul(r_a[1:0], r_b);
    assign w_pp1   = digit_mul(r_a[3:2], r_b);
    assign w_sum1  = r_acc + {w_pp1, 2'b00};
    assign w_early = EARLY_EXIT && (r_a[3:2] == 2'b00);
    assign w_fin_p = (r_state == S_STEP1) ? w_sum1 : P_W'({2'b00, w_pp0});
    assign w_fin_y = w_fin_p[OP_W-1:0];

    // Sequencer: accept, two digit steps (second one optional), hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_acc        <= '0;
            r_res_valid  <= 1'b0;
            r_res_id     <= 1'b0;
            r_res_p      <= '0;
            r_res_z      <= 1'b0;
            r_res_n      <= 1'b0;
            r_res_c      <= 1'b0;
            r_res_v      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_a          <= w_grant0 ? req0_a : req1_a;
                        r_b          <= w_grant0 ? req0_b : req1_b;
                        r_id         <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_acc        <= '0;
                        r_state      <= S_STEP0;
                    end
                end
                S_STEP0, S_STEP1: begin
                    r_acc <= w_fin_p;
                    if (r_state == S_STEP0 && !w_early) begin
                        r_state <= S_STEP1;
                    end else begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_id;
                        r_res_p     <= w_fin_p;
                        r_res_z     <= (w_fin_y == '0);
                        r_res_n     <= w_fin_y[OP_W-1];
                        r_res_c     <= |w_fin_p[P_W-1:OP_W];
                        r_res_v     <= (r_a != '0) && (r_b[OP_W-1] != w_fin_y[OP_W-1]);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_p     = r_res_p;
    assign res_y     = r_res_p[OP_W-1:0];
    assign res_z     = r_res_z;
    assign res_n     = r_res_n;
    assign res_c     = r_res_c;
    assign res_v     = r_res_v;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl: directed vector table plus hand-written
// arbitration, back-pressure and mid-operation reset sequences.
module tb_mul_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic       res_valid, res_ready, res_id;
    logic [7:0] res_p;
    logic [3:0] res_y;
    logic       res_z, res_n, res_c, res_v, busy;

    int checks   = 0;
    int failures = 0;

    mul_seq_ctrl #(.EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_p(res_p), .res_y(res_y), .res_z(res_z), .res_n(res_n),
        .res_c(res_c), .res_v(res_v), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        int         lat;
        logic [7:0] p;
        logic [3:0] y;
        logic [3:0] zncv;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Wait (bounded) for res_valid; returns cycles counted from the accept cycle
    task automatic wait_result(output int lat);
        lat = 1;
        while (!res_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issue one table vector, check grant, latency and the full result
    task automatic run_vec(input vec_t v);
        int lat;
        if (v.id == 1'b0) begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b;
        end else begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b;
        end
        #1;
        check("grant", 32'({req0_ready, req1_ready}), v.id ? 32'd1 : 32'd2);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~v.a; req0_b = ~v.b; req1_a = ~v.a; req1_b = ~v.b;
        wait_result(lat);
        check("latency", 32'(lat), 32'(v.lat));
        check("res_id", 32'(res_id), 32'(v.id));
        check("res_p", 32'(res_p), 32'(v.p));
        check("res_y", 32'(res_y), 32'(v.y));
        check("flags_zncv", 32'({res_z, res_n, res_c, res_v}), 32'(v.zncv));
        @(posedge clk); #1;
        check("drop_after_take", 32'({res_valid, busy}), 32'd0);
    endtask

    initial begin
        int   lat;
        int   viol;
        int   ids[$];
        logic exp_id;

        vecs[0] = '{1'b0, 4'd3,  4'd5,  2, 8'h0F, 4'hF, 4'b0101};
        vecs[1] = '{1'b1, 4'd15, 4'd15, 3, 8'hE1, 4'h1, 4'b0011};
        vecs[2] = '{1'b0, 4'd0,  4'd9,  2, 8'h00, 4'h0, 4'b1000};
        vecs[3] = '{1'b0, 4'd4,  4'd4,  3, 8'h10, 4'h0, 4'b1010};
        vecs[4] = '{1'b1, 4'd8,  4'd3,  3, 8'h18, 4'h8, 4'b0111};
        vecs[5] = '{1'b0, 4'd2,  4'd15, 2, 8'h1E, 4'hE, 4'b0110};

        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({res_valid, res_id, res_p, res_y, res_z, res_n, res_c, res_v, busy}), 32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both requesters continuously valid from reset: grants alternate
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        viol = 0;
        for (int c = 0; c < 40 && ids.size() < 4; c++) begin
            if ((req0_ready && req1_ready) || ((req0_ready || req1_ready) && busy)) viol++;
            if (req0_ready) ids.push_back(0);
            if (req1_ready) ids.push_back(1);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count", 32'(ids.size()), 32'd4);
        check("rr_ready_rules", 32'(viol), 32'd0);
        for (int i = 0; i < ids.size(); i++) begin
            exp_id = 1'(i % 2);
            check("rr_order", 32'(ids[i]), 32'(exp_id));
        end
        for (int c = 0; c < 10 && (busy || res_valid); c++) begin
            @(posedge clk); #1;
        end
        check("rr_drain", 32'({busy, res_valid}), 32'd0);

        // Result back-pressure while another requester waits
        res_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd7;
        #1;
        check("bp_grant", 32'({req0_ready, req1_ready}), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd5;
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            check("bp_hold",
                  32'({res_valid, res_id, res_p, res_y, res_z, res_n, res_c, res_v, req0_ready, req1_ready, busy}),
                  32'({1'b1, 1'b1, 8'h2A, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}));
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({res_valid, busy, req0_ready}), 32'b001);
        req0_valid = 1'b0;

        // Reset while in STEP1 discards the operation; req0 wins the next tie
        req0_valid = 1'b1; req0_a = 4'd8; req0_b = 4'd3;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_busy", 32'({busy, res_valid}), 32'b10);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset", 32'({res_valid, busy, res_id, res_p, res_z, res_n, res_c, res_v}), 32'd0);
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_a = 4'd1; req1_b = 4'd1;
        #1;
        check("post_reset_tie", 32'({req0_ready, req1_ready}), 32'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_result(lat);
        check("post_reset_result", 32'({res_valid, res_id, res_p}), 32'({1'b1, 1'b0, 8'h18}));
        @(posedge clk); #1;
        check("post_reset_idle", 32'({res_valid, busy}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
